// File: rtl/hall_call_queue.sv
// Hall-call front end: filters and dedupes button presses, buffers legal calls in a FIFO,
// issues one-cycle dispatcher requests and keeps the hall lamps lit until serviced.
module hall_call_queue #(
    parameter int NUM_FLOORS = 8,
    parameter int FLOOR_W    = 3,
    parameter int DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      btn_valid,
    input  logic [FLOOR_W-1:0]        btn_floor,
    input  logic                      btn_dir,
    input  logic                      hold,
    input  logic                      clear_valid,
    input  logic [FLOOR_W-1:0]        clear_floor,
    input  logic                      clear_dir,
    output logic                      request,
    output logic [FLOOR_W-1:0]        request_floor,
    output logic                      request_dir,
    output logic [NUM_FLOORS-1:0]     lamp_up,
    output logic [NUM_FLOORS-1:0]     lamp_dn,
    output logic                      overflow,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [FLOOR_W:0]       NUM_FLOORS_C = (FLOOR_W+1)'(NUM_FLOORS);
    localparam logic [FLOOR_W-1:0]     TOP_FLOOR    = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [CNT_W-1:0]       DEPTH_C      = CNT_W'(DEPTH);

    // One-hot lamp mask for a floor; out-of-range floors give an all-zero mask.
    function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            oh[i] = (FLOOR_W'(i) == f);
        end
        return oh;
    endfunction

    logic [FLOOR_W:0]         fifo_q [DEPTH];
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [NUM_FLOORS-1:0]    lamp_up_q, lamp_up_d, lamp_dn_q, lamp_dn_d;
    logic                     request_q, request_d, overflow_q, overflow_d;
    logic [FLOOR_W-1:0]       req_floor_q, req_floor_d;
    logic                     req_dir_q, req_dir_d;
    logic [NUM_FLOORS-1:0]    clr_mask_s, btn_mask_s, up_clr_s, dn_clr_s;
    logic                     legal_s, dup_s, fresh_s, pop_s, push_s;

    // Clear first, then legality/dedupe against post-clear lamps, then push/pop decisions.
    always_comb begin
        clr_mask_s = '0;
        btn_mask_s = floor_onehot(btn_floor);
        up_clr_s   = lamp_up_q;
        dn_clr_s   = lamp_dn_q;
        if (clear_valid) begin
            clr_mask_s = floor_onehot(clear_floor);
        end else begin
            clr_mask_s = '0;
        end
        if (clear_dir) begin
            up_clr_s = lamp_up_q & ~clr_mask_s;
        end else begin
            dn_clr_s = lamp_dn_q & ~clr_mask_s;
        end

        legal_s = btn_valid && ({1'b0, btn_floor} < NUM_FLOORS_C)
                  && !(btn_dir && (btn_floor == TOP_FLOOR))
                  && !(!btn_dir && (btn_floor == {FLOOR_W{1'b0}}));
        if (btn_dir) begin
            dup_s = |(up_clr_s & btn_mask_s);
        end else begin
            dup_s = |(dn_clr_s & btn_mask_s);
        end
        fresh_s    = legal_s && !dup_s;
        pop_s      = (count_q != {CNT_W{1'b0}}) && !hold;
        push_s     = fresh_s && ((count_q < DEPTH_C) || pop_s);
        overflow_d = fresh_s && !push_s;

        lamp_up_d = up_clr_s;
        lamp_dn_d = dn_clr_s;
        if (push_s && btn_dir) begin
            lamp_up_d = up_clr_s | btn_mask_s;
        end else if (push_s) begin
            lamp_dn_d = dn_clr_s | btn_mask_s;
        end else begin
            lamp_up_d = up_clr_s;
        end

        request_d   = pop_s;
        req_floor_d = req_floor_q;
        req_dir_d   = req_dir_q;
        if (pop_s) begin
            req_floor_d = fifo_q[rd_ptr_q][FLOOR_W-1:0];
            req_dir_d   = fifo_q[rd_ptr_q][FLOOR_W];
        end else begin
            req_floor_d = req_floor_q;
        end

        rd_ptr_d = pop_s  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State and output registers; reset discards queued calls and lamps at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            lamp_up_q   <= '0;
            lamp_dn_q   <= '0;
            request_q   <= 1'b0;
            overflow_q  <= 1'b0;
            req_floor_q <= '0;
            req_dir_q   <= 1'b0;
        end else begin
            if (push_s) begin
                fifo_q[wr_ptr_q] <= {btn_dir, btn_floor};
            end
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            lamp_up_q   <= lamp_up_d;
            lamp_dn_q   <= lamp_dn_d;
            request_q   <= request_d;
            overflow_q  <= overflow_d;
            req_floor_q <= req_floor_d;
            req_dir_q   <= req_dir_d;
        end
    end

    assign request       = request_q;
    assign request_floor = req_floor_q;
    assign request_dir   = req_dir_q;
    assign lamp_up       = lamp_up_q;
    assign lamp_dn       = lamp_dn_q;
    assign overflow      = overflow_q;
    assign count         = count_q;
endmodule

// File: tb/tb_hall_call_queue.sv
// Bench for hall_call_queue: directed scenarios then random traffic, each edge checked
// against a queue-based model of the hall-call rules.
module tb_hall_call_queue;
    localparam int NF = 8;
    localparam int DP = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_valid = 1'b0, btn_dir = 1'b0, hold = 1'b0;
    logic       clear_valid = 1'b0, clear_dir = 1'b0;
    logic [2:0] btn_floor = 3'd0, clear_floor = 3'd0;
    logic       request, request_dir, overflow;
    logic [2:0] request_floor;
    logic [7:0] lamp_up, lamp_dn;
    logic [2:0] count;

    hall_call_queue #(.NUM_FLOORS(NF), .FLOOR_W(3), .DEPTH(DP)) dut (
        .clk(clk), .reset(reset),
        .btn_valid(btn_valid), .btn_floor(btn_floor), .btn_dir(btn_dir),
        .hold(hold),
        .clear_valid(clear_valid), .clear_floor(clear_floor), .clear_dir(clear_dir),
        .request(request), .request_floor(request_floor), .request_dir(request_dir),
        .lamp_up(lamp_up), .lamp_dn(lamp_dn), .overflow(overflow), .count(count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit [3:0] m_q[$];
    bit [7:0] m_up, m_dn;
    bit       e_req, e_dir, e_ovf;
    bit [2:0] e_floor;

    task automatic model_reset();
        m_q.delete();
        m_up = 8'd0; m_dn = 8'd0;
        e_req = 1'b0; e_dir = 1'b0; e_ovf = 1'b0; e_floor = 3'd0;
    endtask

    task automatic model_edge();
        bit legal, lit, popping, accept;
        bit [3:0] head;
        if (clear_valid) begin
            if (clear_dir) m_up[clear_floor] = 1'b0;
            else           m_dn[clear_floor] = 1'b0;
        end
        legal = btn_valid && (int'(btn_floor) < NF)
                && !(btn_dir && int'(btn_floor) == NF - 1)
                && !(!btn_dir && btn_floor == 3'd0);
        lit = btn_dir ? m_up[btn_floor] : m_dn[btn_floor];
        popping = (m_q.size() > 0) && !hold;
        accept = legal && !lit && (m_q.size() < DP || popping);
        e_ovf = legal && !lit && !accept;
        e_req = popping;
        if (popping) begin
            head = m_q.pop_front();
            e_floor = head[2:0];
            e_dir = head[3];
        end
        if (accept) begin
            m_q.push_back({btn_dir, btn_floor});
            if (btn_dir) m_up[btn_floor] = 1'b1;
            else         m_dn[btn_floor] = 1'b1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("request", 32'(request), 32'(e_req));
        chk("request_floor", 32'(request_floor), 32'(e_floor));
        chk("request_dir", 32'(request_dir), 32'(e_dir));
        chk("lamp_up", 32'(lamp_up), 32'(m_up));
        chk("lamp_dn", 32'(lamp_dn), 32'(m_dn));
        chk("overflow", 32'(overflow), 32'(e_ovf));
        chk("count", 32'(count), 32'(m_q.size()));
    endtask

    task automatic step(input logic bv, input logic [2:0] bf, input logic bd, input logic h,
                        input logic cv, input logic [2:0] cf, input logic cd);
        btn_valid = bv; btn_floor = bf; btn_dir = bd; hold = h;
        clear_valid = cv; clear_floor = cf; clear_dir = cd;
        if (!reset) model_reset();
        else        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(input logic h);
        step(1'b0, 3'd0, 1'b0, h, 1'b0, 3'd0, 1'b0);
    endtask

    initial begin
        model_reset();
        // Reset held low while presses strobe
        step(1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        step(1'b1, 3'd5, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0);
        reset = 1'b1;
        idle(1'b0);

        // Basic: two consecutive presses, two consecutive issues
        step(1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        step(1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1);
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0);

        // Dedupe and illegal calls
        step(1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        step(1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        step(1'b1, 3'd7, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        step(1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        idle(1'b0);
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1);

        // Full: four accepted, fifth overflows
        step(1'b1, 3'd1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        step(1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        step(1'b1, 3'd4, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        step(1'b1, 3'd7, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        step(1'b1, 3'd6, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        // Full with pop: push accepted, count stays
        step(1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        // Clear and re-press the same call in one cycle
        step(1'b1, 3'd2, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0);
        for (int i = 0; i < 6; i++) idle(1'b0);

        // Reset mid-queue
        step(1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        step(1'b1, 3'd5, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        step(1'b1, 3'd6, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        idle(1'b0);
        reset = 1'b1;
        idle(1'b0);
        idle(1'b0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 1'($urandom),
                 1'($urandom_range(0, 9) < 4),
                 1'($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), 1'($urandom));
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b0;
                idle(1'b0);
                reset = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
